alu: RTL and testbench

- Small registered integer ALU for the mid-term datapath.
- Takes two unsigned DATA_WIDTH operands and an OPCODE_WIDTH operation select, and computes add, subtract, multiply or bitwise AND.
- Captures the result in an output register on the rising clock edge when enabled.
- Sits between the operand/register-file stage and the writeback stage.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 57 +++++
 rtl/alu.sv | 43 ++++
 tb/tb_alu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and helper for the ALU datapath.
// Optional build macro used by the ALU: ALU_SATURATE_EN (clamp instead of wrap).
package alu_pkg;

    localparam int unsigned ALU_OP_ADD = 0;
    localparam int unsigned ALU_OP_SUB = 1;
    localparam int unsigned ALU_OP_MUL = 2;
    localparam int unsigned ALU_OP_AND = 3;

    // All-ones value of the given width (1..64), used as the saturation limit.
    function automatic logic [63:0] alu_all_ones(input int unsigned width);
        return {64{1'b1}} >> (64 - width);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational result logic (decode, arithmetic, clamping).
// Build macro ALU_SATURATE_EN selects clamping instead of modular wrap for
// ADD, SUB and MUL; AND and unused opcodes behave the same in both builds.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic [OPCODE_WIDTH-1:0] op_code_i,
    input  logic [DATA_WIDTH-1:0]   op0_i,
    input  logic [DATA_WIDTH-1:0]   op1_i,
    output logic [DATA_WIDTH-1:0]   result_o
);

`ifdef ALU_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(alu_all_ones(DATA_WIDTH));

    logic [DATA_WIDTH:0]     sum_w;
    logic [DATA_WIDTH-1:0]   diff_w;
    logic [2*DATA_WIDTH-1:0] prod_w;

    // Clamping arithmetic: carry-out, borrow or any upper product bit pins the result.
    always_comb begin
        sum_w  = {1'b0, op0_i} + {1'b0, op1_i};
        diff_w = op0_i - op1_i;
        prod_w = {{DATA_WIDTH{1'b0}}, op0_i} * {{DATA_WIDTH{1'b0}}, op1_i};
        case (op_code_i)
            OPCODE_WIDTH'(ALU_OP_ADD): result_o = sum_w[DATA_WIDTH] ? SAT_MAX : sum_w[DATA_WIDTH-1:0];
            OPCODE_WIDTH'(ALU_OP_SUB): result_o = (op1_i > op0_i) ? '0 : diff_w;
            OPCODE_WIDTH'(ALU_OP_MUL): result_o = (|prod_w[2*DATA_WIDTH-1:DATA_WIDTH]) ? SAT_MAX
                                                                                     : prod_w[DATA_WIDTH-1:0];
            OPCODE_WIDTH'(ALU_OP_AND): result_o = op0_i & op1_i;
            default:                   result_o = '0;
        endcase
    end
`else
    logic [DATA_WIDTH-1:0] sum_w;
    logic [DATA_WIDTH-1:0] diff_w;
    logic [DATA_WIDTH-1:0] prod_w;

    // Modular arithmetic: every result is simply truncated to DATA_WIDTH bits.
    always_comb begin
        sum_w  = op0_i + op1_i;
        diff_w = op0_i - op1_i;
        prod_w = op0_i * op1_i;
        case (op_code_i)
            OPCODE_WIDTH'(ALU_OP_ADD): result_o = sum_w;
            OPCODE_WIDTH'(ALU_OP_SUB): result_o = diff_w;
            OPCODE_WIDTH'(ALU_OP_MUL): result_o = prod_w;
            OPCODE_WIDTH'(ALU_OP_AND): result_o = op0_i & op1_i;
            default:                   result_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU (add/sub/mul/and) with one-cycle latency.
// Build macro ALU_SATURATE_EN switches the arithmetic to clamping; the
// register, enable and asynchronous reset behave identically in both builds.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [DATA_WIDTH-1:0]   op0,
    input  logic [DATA_WIDTH-1:0]   op1,
    output logic [DATA_WIDTH-1:0]   out
);

    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] out_q;

    alu_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_core (
        .op_code_i(op_code),
        .op0_i    (op0),
        .op1_i    (op1),
        .result_o (result_d)
    );

    // Result register: loads only when enabled, cleared at once by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (enable) begin
            out_q <= result_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu (DATA_WIDTH=4, OPCODE_WIDTH=2).
// Honours ALU_SATURATE_EN in its reference model when the macro is defined.
module tb_alu;

    localparam int DW  = 4;
    localparam int OW  = 2;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [OW-1:0] op_code = '0;
    logic [DW-1:0] op0 = '0;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] out;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int model_out = 0;
    bit done = 1'b0;

    alu #(DW, OW) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .op_code(op_code),
        .op0    (op0),
        .op1    (op1),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Reference: the arithmetic rules written with plain integers.
    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0: begin
                r = a + b;
`ifdef ALU_SATURATE_EN
                if (r > MOD - 1) r = MOD - 1;
`else
                r = r % MOD;
`endif
            end
            1: begin
                r = a - b;
`ifdef ALU_SATURATE_EN
                if (r < 0) r = 0;
`else
                r = (r + MOD) % MOD;
`endif
            end
            2: begin
                r = a * b;
`ifdef ALU_SATURATE_EN
                if (r > MOD - 1) r = MOD - 1;
`else
                r = r % MOD;
`endif
            end
            3: r = a & b;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: out=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; queue the expected result if enabled.
    task automatic issue(input int op, input int a, input int b, input bit en);
        @(negedge clk);
        op_code = OW'(op);
        op0     = DW'(a);
        op1     = DW'(b);
        enable  = en;
        if (en) exp_q.push_back(ref_alu(op, a, b));
    endtask

    // Monitor: after each rising edge, compare out with the scoreboard.
    initial begin
        bit en_s, rst_s;
        int exp_v;
        while (!done) begin
            @(posedge clk);
            en_s  = enable;
            rst_s = reset;
            #1;
            if (done) break;
            if (rst_s) begin
                check("reset_hold", int'(out), 0);
            end else if (en_s) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL underflow: out=%0d expected=<none> at t=%0t", out, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    model_out = exp_v;
                    check("load", int'(out), exp_v);
                end
            end else begin
                check("hold", int'(out), model_out);
            end
        end
    end

    initial begin
        // Asynchronous reset with no clock edge in between.
        #1 reset = 1'b1;
        #1 check("reset_async", int'(out), 0);
        @(negedge clk);
        reset = 1'b0;
        model_out = 0;
        repeat (3) issue(0, 5, 5, 1'b0);

        // Basic operations on 2,2.
        for (int op = 0; op < 4; op++) issue(op, 2, 2, 1'b1);

        // Wrap / clamp boundaries.
        issue(0, 9, 9, 1'b1);
        issue(1, 1, 2, 1'b1);
        issue(2, 5, 4, 1'b1);
        issue(2, 3, 5, 1'b1);
        issue(0, 15, 15, 1'b1);
        issue(1, 0, 15, 1'b1);

        // Hold: load 7 then change inputs with enable low.
        issue(0, 3, 4, 1'b1);
        repeat (4) issue(0, 1, 1, 1'b0);
        issue(0, 1, 1, 1'b1);

        // Reset mid-stream discards the pending result.
        repeat (3) issue(0, 6, 6, 1'b1);
        issue(0, 6, 6, 1'b1);
        #2 reset = 1'b1;
        exp_q.delete();
        model_out = 0;
        #1 check("reset_mid", int'(out), 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 6, 6, 1'b1);
        issue(0, 6, 6, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                  int'($urandom_range(0, MOD - 1)), ($urandom_range(0, 3) != 0));
        issue(0, 0, 0, 1'b0);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
